// File: rtl/piezo_echo_capture.sv
// piezo_echo_capture: qualifies synchronized piezo echoes, timestamps
// them into a small FIFO and exposes control/status over Avalon-MM.
module piezo_echo_capture #(
  parameter int MIN_HIGH = 3,
  parameter int HOLDOFF  = 16,
  parameter int DEPTH    = 4
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iPIEZO_IN,
  input  logic [31:0] iTIME,
  input  logic        iTX_ENABLE,
  input  logic [1:0]  iADDRESS,
  input  logic        iREAD,
  input  logic        iWRITE,
  input  logic [31:0] iWRITEDATA,
  output logic [31:0] oREADDATA,
  output logic        oREADDATAVALID,
  output logic        oIRQ
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0] RUN_LAST = 4'(MIN_HIGH - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_QUALIFY = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t state, stateNxt;
  logic pzMeta, pzSync;
  logic [3:0] runCnt, runNxt;
  logic [7:0] holdCnt, holdNxt;
  logic [31:0] tmoCnt, tmoNxt;
  logic [31:0] timeoutReg, cand;
  logic contMode, irqEn, ovfFlag, tmoFlag;
  logic capture, tmoHit, latchCand;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic ctrlWr, tmoWr, clrReq, live, tmoDue;
  logic push, pop, doWrite, full;
  logic [31:0] pushData, status;

  assign ctrlWr  = iWRITE && (iADDRESS == 2'd0);
  assign tmoWr   = iWRITE && (iADDRESS == 2'd2);
  assign clrReq  = ctrlWr && iWRITEDATA[1];
  assign live    = pzSync && !iTX_ENABLE;
  assign tmoDue  = (timeoutReg != '0)
                && (tmoCnt >= timeoutReg - 32'd1);
  assign full    = (count == FULL_CNT);
  assign pop     = iREAD && (iADDRESS == 2'd1) && (count != '0);
  assign push    = capture && !clrReq;
  assign doWrite = push && (!full || pop);
  // With MIN_HIGH=1 the capture happens in ARMED, before cand is loaded
  assign pushData = (state == S_ARMED) ? iTIME : cand;
  assign status  = {18'd0, contMode, irqEn, 8'(count),
                    tmoFlag, ovfFlag, 2'(state)};
  assign oIRQ    = irqEn && (count != '0);

  // two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      pzMeta <= 1'b0;
      pzSync <= 1'b0;
    end else begin
      pzMeta <= iPIEZO_IN;
      pzSync <= pzMeta;
    end
  end

  // state, qualification run, holdoff and timeout counters
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state   <= S_IDLE;
      runCnt  <= '0;
      holdCnt <= '0;
      tmoCnt  <= '0;
      cand    <= '0;
    end else begin
      state   <= stateNxt;
      runCnt  <= runNxt;
      holdCnt <= holdNxt;
      tmoCnt  <= tmoNxt;
      if (latchCand) cand <= iTIME;
    end
  end

  // next state: forced idle, capture, timeout, then run tracking
  always_comb begin
    stateNxt  = state;
    runNxt    = runCnt;
    holdNxt   = holdCnt;
    tmoNxt    = tmoCnt;
    capture   = 1'b0;
    tmoHit    = 1'b0;
    latchCand = 1'b0;
    if (ctrlWr && !iWRITEDATA[0]) begin
      stateNxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ctrlWr) begin
            stateNxt = S_ARMED;
            runNxt   = '0;
            tmoNxt   = '0;
          end
        end
        S_ARMED, S_QUALIFY: begin
          if (live && (runCnt == RUN_LAST)) begin
            stateNxt = S_HOLD;
            capture  = 1'b1;
            runNxt   = '0;
            holdNxt  = '0;
            tmoNxt   = '0;
          end else if (tmoDue) begin
            stateNxt = S_IDLE;
            tmoHit   = 1'b1;
            runNxt   = '0;
          end else if (live) begin
            stateNxt  = S_QUALIFY;
            latchCand = (state == S_ARMED);
            runNxt    = runCnt + 4'd1;
            tmoNxt    = tmoCnt + 32'd1;
          end else begin
            stateNxt = S_ARMED;
            runNxt   = '0;
            tmoNxt   = tmoCnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (holdCnt == HOLD_LAST) begin
            stateNxt = contMode ? S_ARMED : S_IDLE;
          end else begin
            holdNxt = holdCnt + 8'd1;
          end
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a clear flushes everything
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clrReq) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + AW'(1);
      if (pop) rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + AW'(1);
      count <= count + CW'(doWrite) - CW'(pop);
    end
  end

  // timestamp storage
  always_ff @(posedge iCLK) begin
    if (doWrite) mem[wrPtr] <= pushData;
  end

  // control bits, timeout limit and sticky flags
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      contMode   <= 1'b0;
      irqEn      <= 1'b0;
      ovfFlag    <= 1'b0;
      tmoFlag    <= 1'b0;
      timeoutReg <= '0;
    end else begin
      if (ctrlWr) begin
        contMode <= iWRITEDATA[2];
        irqEn    <= iWRITEDATA[3];
      end
      if (tmoWr) timeoutReg <= iWRITEDATA;
      if (clrReq) begin
        ovfFlag <= 1'b0;
        tmoFlag <= 1'b0;
      end else begin
        if (push && full && !pop) ovfFlag <= 1'b1;
        if (tmoHit) tmoFlag <= 1'b1;
      end
    end
  end

  // registered read port, data held between reads
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      oREADDATA      <= '0;
      oREADDATAVALID <= 1'b0;
    end else begin
      oREADDATAVALID <= iREAD;
      if (iREAD) begin
        unique case (iADDRESS)
          2'd0: oREADDATA <= status;
          2'd1: oREADDATA <= (count != '0) ? mem[rdPtr] : '1;
          2'd2: oREADDATA <= timeoutReg;
          2'd3: oREADDATA <= iTIME;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_piezo_echo_capture.sv
// tb_piezo_echo_capture: directed and random stimulus checked
// against a queue-based behavioural model of the capture block.
module tb_piezo_echo_capture;
  localparam int MIN_HIGH = 3;
  localparam int HOLDOFF  = 16;
  localparam int DEPTH    = 4;
  localparam int P_IDLE   = 0;
  localparam int P_LISTEN = 1;
  localparam int P_HOLD   = 2;

  logic iCLK = 1'b0;
  logic iRESETn = 1'b0;
  logic iPIEZO_IN = 1'b0;
  logic iTX_ENABLE = 1'b0;
  logic iREAD = 1'b0;
  logic iWRITE = 1'b0;
  logic [1:0] iADDRESS = 2'd0;
  logic [31:0] iTIME = 32'd0;
  logic [31:0] iWRITEDATA = 32'd0;
  logic [31:0] oREADDATA;
  logic oREADDATAVALID;
  logic oIRQ;

  int vectors = 0;
  int miscompares = 0;

  always #5 iCLK = ~iCLK;

  piezo_echo_capture #(
    .MIN_HIGH(MIN_HIGH),
    .HOLDOFF(HOLDOFF),
    .DEPTH(DEPTH)
  ) dut (
    .iCLK(iCLK),
    .iRESETn(iRESETn),
    .iPIEZO_IN(iPIEZO_IN),
    .iTIME(iTIME),
    .iTX_ENABLE(iTX_ENABLE),
    .iADDRESS(iADDRESS),
    .iREAD(iREAD),
    .iWRITE(iWRITE),
    .iWRITEDATA(iWRITEDATA),
    .oREADDATA(oREADDATA),
    .oREADDATAVALID(oREADDATAVALID),
    .oIRQ(oIRQ)
  );

  // behavioural model state
  logic h1, h2;
  int phase;
  int run;
  int held;
  int unsigned waited;
  logic [31:0] cand;
  logic [31:0] q[$];
  bit ovf, tof, cont, irqEn;
  logic [31:0] mTo;
  logic [31:0] mData;
  bit mValid;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] statusWord();
    logic [1:0] code;
    if (phase == P_IDLE) code = 2'd0;
    else if (phase == P_HOLD) code = 2'd3;
    else if (run == 0) code = 2'd1;
    else code = 2'd2;
    return {18'd0, cont, irqEn, 8'(q.size()), tof, ovf, code};
  endfunction

  task automatic modelStep();
    logic syncNow, live, wr0, clr, doPush;
    logic [31:0] pushVal;
    if (!iRESETn) begin
      h1 = 0; h2 = 0; phase = P_IDLE; run = 0; held = 0;
      waited = 0; cand = 0; q.delete(); ovf = 0; tof = 0;
      cont = 0; irqEn = 0; mTo = 0; mData = 0; mValid = 0;
      return;
    end
    syncNow = h2;
    h2 = h1;
    h1 = iPIEZO_IN;
    live = syncNow && !iTX_ENABLE;
    mValid = iREAD;
    if (iREAD) begin
      case (iADDRESS)
        2'd0: mData = statusWord();
        2'd1: mData = (q.size() != 0) ? q[0] : 32'hFFFF_FFFF;
        2'd2: mData = mTo;
        default: mData = iTIME;
      endcase
    end
    wr0 = iWRITE && (iADDRESS == 2'd0);
    clr = wr0 && iWRITEDATA[1];
    doPush = 0;
    pushVal = 0;
    if (wr0 && !iWRITEDATA[0]) begin
      phase = P_IDLE;
    end else if (phase == P_IDLE) begin
      if (wr0) begin
        phase = P_LISTEN; run = 0; waited = 0;
      end
    end else if (phase == P_LISTEN) begin
      if (live) begin
        if (run == 0) cand = iTIME;
        run++;
      end else begin
        run = 0;
      end
      if (run == MIN_HIGH) begin
        doPush = 1; pushVal = cand; phase = P_HOLD;
        held = 0; run = 0; waited = 0;
      end else begin
        waited++;
        if (mTo != 0 && waited >= mTo) begin
          phase = P_IDLE; tof = 1; run = 0;
        end
      end
    end else begin
      held++;
      if (held == HOLDOFF) phase = cont ? P_LISTEN : P_IDLE;
    end
    if (clr) begin
      q.delete(); ovf = 0; tof = 0;
    end else begin
      if (iREAD && iADDRESS == 2'd1 && q.size() != 0) void'(q.pop_front());
      if (doPush) begin
        if (q.size() < DEPTH) q.push_back(pushVal);
        else ovf = 1;
      end
    end
    if (wr0) begin
      cont = iWRITEDATA[2];
      irqEn = iWRITEDATA[3];
    end
    if (iWRITE && iADDRESS == 2'd2) mTo = iWRITEDATA;
  endtask

  initial forever begin
    @(posedge iCLK);
    modelStep();
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge iCLK);
    if (iRESETn) begin
      check("rvalid", {31'd0, oREADDATAVALID}, {31'd0, mValid});
      check("rdata", oREADDATA, mData);
      check("irq", {31'd0, oIRQ}, {31'd0, irqEn && (q.size() != 0)});
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge iCLK);
      #2;
      iTIME = iTIME + 32'd1;
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    iWRITE = 1; iADDRESS = a; iWRITEDATA = d;
    tick();
    iWRITE = 0;
  endtask

  task automatic rdChk(string name, logic [1:0] a, logic [31:0] exp);
    iREAD = 1; iADDRESS = a;
    tick();
    iREAD = 0;
    #1;
    check(name, oREADDATA, exp);
  endtask

  // high for hi ticks; t0 is the iTIME seen on the first synced-high cycle
  task automatic pulse(int hi, logic [31:0] t0);
    iTIME = t0 - 32'd2;
    iPIEZO_IN = 1;
    tick(hi);
    iPIEZO_IN = 0;
  endtask

  task automatic resetChecks(string tag);
    check({tag, "_rdata"}, oREADDATA, 32'd0);
    check({tag, "_rvalid"}, {31'd0, oREADDATAVALID}, 32'd0);
    check({tag, "_irq"}, {31'd0, oIRQ}, 32'd0);
  endtask

  initial begin
    logic [31:0] tnow;
    int runLeft;
    tick(3);
    resetChecks("rst");
    iRESETn = 1;
    tick(2);
    rdChk("rst_status", 2'd0, 32'h0);
    rdChk("rst_timeout", 2'd2, 32'h0);
    rdChk("rst_empty", 2'd1, 32'hFFFF_FFFF);

    // single echo, holdoff then idle
    wr(2'd0, 32'h1);
    pulse(3, 32'd1000);
    tick(3);
    rdChk("hold_status", 2'd0, 32'h13);
    tick(20);
    rdChk("idle_status", 2'd0, 32'h10);
    rdChk("echo0", 2'd1, 32'd1000);
    rdChk("empty_status", 2'd0, 32'h0);

    // short pulse rejected, later pulse captured
    wr(2'd0, 32'h1);
    pulse(2, 32'd2000);
    tick(4);
    rdChk("short_status", 2'd0, 32'h1);
    pulse(3, 32'd3000);
    tick(20);
    rdChk("later_echo", 2'd1, 32'd3000);

    // continuous mode overflow
    wr(2'd0, 32'h2);
    wr(2'd0, 32'h5);
    for (int i = 0; i < 6; i++) begin
      pulse(3, 32'd5000 + 32'(100 * i));
      tick(20);
    end
    rdChk("ovf_status", 2'd0, 32'h2045);
    for (int i = 0; i < 4; i++)
      rdChk("ovf_order", 2'd1, 32'd5000 + 32'(100 * i));
    rdChk("ovf_empty", 2'd1, 32'hFFFF_FFFF);

    // pop coincident with push on a full FIFO
    wr(2'd0, 32'h2);
    wr(2'd0, 32'hD);
    for (int i = 0; i < 4; i++) begin
      pulse(3, 32'd7000 + 32'(100 * i));
      tick(20);
    end
    check("irq_full", {31'd0, oIRQ}, 32'd1);
    iTIME = 32'd7998;
    iPIEZO_IN = 1;
    tick(3);
    iPIEZO_IN = 0;
    tick(1);
    rdChk("pop_on_push", 2'd1, 32'd7000);
    rdChk("full_pop_status", 2'd0, 32'h3043);
    rdChk("drain1", 2'd1, 32'd7100);
    rdChk("drain2", 2'd1, 32'd7200);
    rdChk("drain3", 2'd1, 32'd7300);
    rdChk("drain4", 2'd1, 32'd8000);
    check("irq_empty", {31'd0, oIRQ}, 32'd0);

    // transmitter blanking
    wr(2'd0, 32'h2);
    wr(2'd0, 32'h1);
    iTX_ENABLE = 1;
    iPIEZO_IN = 1;
    tick(10);
    iPIEZO_IN = 0;
    tick(4);
    iTX_ENABLE = 0;
    tick(2);
    rdChk("blank_status", 2'd0, 32'h1);
    iTX_ENABLE = 1;
    iPIEZO_IN = 1;
    tick(4);
    iTX_ENABLE = 0;
    iTIME = 32'd9000;
    tick(5);
    iPIEZO_IN = 0;
    tick(20);
    rdChk("unblank_echo", 2'd1, 32'd9000);

    // timeout boundary
    wr(2'd0, 32'h2);
    wr(2'd2, 32'd50);
    wr(2'd0, 32'h1);
    tick(49);
    rdChk("tmo_edge", 2'd0, 32'h1);
    rdChk("tmo_fired", 2'd0, 32'h8);
    wr(2'd0, 32'h2);
    rdChk("tmo_clear", 2'd0, 32'h0);
    wr(2'd2, 32'd0);

    // ignored writes and live time
    wr(2'd1, 32'h1234);
    wr(2'd3, 32'h5678);
    rdChk("ign_status", 2'd0, 32'h0);
    rdChk("ign_fifo", 2'd1, 32'hFFFF_FFFF);
    tnow = iTIME;
    rdChk("live_time", 2'd3, tnow);

    // reset in the middle of qualification
    wr(2'd0, 32'h1);
    iPIEZO_IN = 1;
    tick(4);
    iRESETn = 0;
    #1;
    resetChecks("midrst");
    tick(2);
    iRESETn = 1;
    iPIEZO_IN = 0;
    tick(3);
    rdChk("midrst_status", 2'd0, 32'h0);
    rdChk("midrst_fifo", 2'd1, 32'hFFFF_FFFF);

    // randomized traffic against the model
    runLeft = 0;
    for (int n = 0; n < 4000; n++) begin
      if (runLeft == 0) begin
        iPIEZO_IN = ($urandom_range(0, 2) == 0);
        runLeft = iPIEZO_IN ? $urandom_range(1, 6) : $urandom_range(1, 12);
      end
      runLeft--;
      if ($urandom_range(0, 39) == 0) iTX_ENABLE = ~iTX_ENABLE;
      if ($urandom_range(0, 199) == 0) iTIME = $urandom;
      iADDRESS = 2'($urandom_range(0, 3));
      iREAD = ($urandom_range(0, 99) < 15);
      iWRITE = ($urandom_range(0, 99) < 5);
      if (iADDRESS == 2'd2) begin
        iWRITEDATA = ($urandom_range(0, 2) == 0) ? 32'd0
                   : 32'($urandom_range(10, 120));
      end else begin
        iWRITEDATA = $urandom & 32'hF;
        if ($urandom_range(0, 3) != 0) iWRITEDATA[0] = 1'b1;
        if ($urandom_range(0, 4) != 0) iWRITEDATA[1] = 1'b0;
      end
      tick();
    end
    iREAD = 0;
    iWRITE = 0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
